// File: rtl/pc_conf_loader.sv
// pc_conf_loader: configuration sequencer for the CGRA processing-cell array.
// Takes a 32-bit word stream over valid/ready. It packs every four words into one
// 108-bit conf record plus a 2-bit elastic-buffer enable. Records are written
// into the per-PC output registers in array order. The array is cleared before
// loading, and execution is enabled once every PC holds a fresh record.

`default_nettype none

module pc_conf_loader #(
    parameter int NUM_PC     = 16,
    parameter int CONF_WIDTH = 108,
    parameter int WORD_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [WORD_WIDTH-1:0]        cfg_word_i,
    input  logic                         cfg_word_v_i,
    output logic                         cfg_word_r_o,
    output logic [NUM_PC*CONF_WIDTH-1:0] conf_bits_o,
    output logic [NUM_PC*2-1:0]          eb_en_o,
    output logic                         clr_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         exec_en_o
);

    // Index widths and record layout derived from the parameters.
    localparam int PC_IDX_W = (NUM_PC > 1) ? $clog2(NUM_PC) : 1;
    localparam int ASM_W    = 3 * WORD_WIDTH;        // words 0..2 of a record
    localparam int TAIL_W   = CONF_WIDTH - ASM_W;    // conf bits carried by word 3
    localparam int EB_LSB   = TAIL_W;                // eb_en sits right above the tail

    localparam logic [PC_IDX_W-1:0] LAST_PC  = PC_IDX_W'(NUM_PC - 1);
    localparam logic [1:0]          LAST_WRD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   word_idx_q, word_idx_d;
    logic [PC_IDX_W-1:0]          pc_idx_q, pc_idx_d;
    logic [ASM_W-1:0]             asm_q, asm_d;
    logic [NUM_PC*CONF_WIDTH-1:0] conf_q, conf_d;
    logic [NUM_PC*2-1:0]          eb_q, eb_d;
    logic                         exec_en_q, exec_en_d;

    logic                         word_acc;
    logic                         rec_commit;
    logic                         last_rec;

    // Upper bits of word 3 carry nothing; fold them so they are visibly consumed.
    logic unused_word_bits;
    assign unused_word_bits = ^cfg_word_i[WORD_WIDTH-1:EB_LSB+2];

    // Handshake qualifiers shared by the FSM and the assembly datapath.
    assign word_acc   = (state_q == ST_LOAD) && cfg_word_v_i;
    assign rec_commit = word_acc && (word_idx_q == LAST_WRD);
    assign last_rec   = (pc_idx_q == LAST_PC);

    // Next-state and per-state outputs; abort outranks completion in LOAD.
    always_comb begin
        state_d      = state_q;
        exec_en_d    = exec_en_q;
        cfg_word_r_o = 1'b0;
        clr_o        = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_CLEAR;
                    exec_en_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                clr_o   = 1'b1;
                busy_o  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy_o       = 1'b1;
                cfg_word_r_o = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (rec_commit && last_rec) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                exec_en_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word assembly, record commit into the addressed PC slice, and counters.
    always_comb begin
        word_idx_d = word_idx_q;
        pc_idx_d   = pc_idx_q;
        asm_d      = asm_q;
        conf_d     = conf_q;
        eb_d       = eb_q;

        if (state_q == ST_CLEAR) begin
            word_idx_d = 2'd0;
            pc_idx_d   = '0;
            asm_d      = '0;
        end

        if (word_acc) begin
            unique case (word_idx_q)
                2'd0:    asm_d[0*WORD_WIDTH +: WORD_WIDTH] = cfg_word_i;
                2'd1:    asm_d[1*WORD_WIDTH +: WORD_WIDTH] = cfg_word_i;
                2'd2:    asm_d[2*WORD_WIDTH +: WORD_WIDTH] = cfg_word_i;
                default: asm_d = asm_q;
            endcase
            word_idx_d = word_idx_q + 2'd1;
        end

        // Word 3 closes the record: write it straight into the current PC slice.
        if (rec_commit) begin
            for (int k = 0; k < NUM_PC; k++) begin
                if (pc_idx_q == PC_IDX_W'(k)) begin
                    conf_d[k*CONF_WIDTH +: CONF_WIDTH] = {cfg_word_i[TAIL_W-1:0], asm_q};
                    eb_d[k*2 +: 2]                     = cfg_word_i[EB_LSB +: 2];
                end
            end
            pc_idx_d = last_rec ? '0 : (pc_idx_q + PC_IDX_W'(1));
        end

        // Abort drops any partial record; committed slices stay as they are.
        if ((state_q == ST_LOAD) && abort_i) begin
            word_idx_d = 2'd0;
            pc_idx_d   = '0;
            asm_d      = '0;
        end
    end

    // State, counters and output registers; reset clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_idx_q <= 2'd0;
            pc_idx_q   <= '0;
            asm_q      <= '0;
            conf_q     <= '0;
            eb_q       <= '0;
            exec_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            pc_idx_q   <= pc_idx_d;
            asm_q      <= asm_d;
            conf_q     <= conf_d;
            eb_q       <= eb_d;
            exec_en_q  <= exec_en_d;
        end
    end

    assign conf_bits_o = conf_q;
    assign eb_en_o     = eb_q;
    assign exec_en_o   = exec_en_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_conf_loader.sv
// Testbench for pc_conf_loader with two PCs: table-driven load scenarios,
// randomized loads against a record-level model, and reset corner cases.

module tb_pc_conf_loader;

    localparam int NUM_PC = 2;
    localparam int CW     = 108;
    localparam int NWORDS = 4 * NUM_PC;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   start_i;
    logic                   abort_i;
    logic [31:0]            cfg_word_i;
    logic                   cfg_word_v_i;
    logic                   cfg_word_r_o;
    logic [NUM_PC*CW-1:0]   conf_bits_o;
    logic [NUM_PC*2-1:0]    eb_en_o;
    logic                   clr_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   exec_en_o;

    int checks = 0;
    int errors = 0;

    // Record-level model of what each PC slice should hold.
    logic [CW-1:0] mdl_conf [NUM_PC];
    logic [1:0]    mdl_eb   [NUM_PC];
    logic [31:0]   words    [NWORDS];

    typedef struct {
        bit pre_reset;   // reset (and clear the model) before this load
        bit rnd;         // random words instead of the reference vectors
        int gap;         // idle valid cycles after each accepted word
        int abort_at;    // abort offered together with this word index, -1 none
        bit poke_start;  // pulse start_i during LOAD and during DONE
        bit abort_done;  // pulse abort_i during DONE
        int exp_done;    // expected done_o cycle counted from the start edge, -1 none
        bit exp_exec;    // expected exec_en_o after the sequence
    } vec_t;

    localparam int NROWS = 10;
    vec_t tbl [NROWS];

    pc_conf_loader #(.NUM_PC(NUM_PC), .CONF_WIDTH(CW), .WORD_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cfg_word_i   (cfg_word_i),
        .cfg_word_v_i (cfg_word_v_i),
        .cfg_word_r_o (cfg_word_r_o),
        .conf_bits_o  (conf_bits_o),
        .eb_en_o      (eb_en_o),
        .clr_o        (clr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .exec_en_o    (exec_en_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        for (int pc = 0; pc < NUM_PC; pc++) begin
            chkw($sformatf("conf_pc%0d", pc), 128'(conf_bits_o[pc*CW +: CW]), 128'(mdl_conf[pc]));
            chkw($sformatf("eb_pc%0d", pc), 128'(eb_en_o[pc*2 +: 2]), 128'(mdl_eb[pc]));
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk1({tag, "_ready"}, cfg_word_r_o, 1'b0);
        chk1({tag, "_clr"},   clr_o,        1'b0);
        chk1({tag, "_busy"},  busy_o,       1'b0);
        chk1({tag, "_done"},  done_o,       1'b0);
        chk1({tag, "_exec"},  exec_en_o,    1'b0);
        chk_model();
    endtask

    task automatic fill_plan_words();
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h33333333; words[3] = 32'h00002ABC;
        words[4] = 32'hAAAAAAAA; words[5] = 32'hBBBBBBBB;
        words[6] = 32'hCCCCCCCC; words[7] = 32'h00001DEF;
    endtask

    // Hold reset for two cycles; noisy drives start/valid high meanwhile.
    task automatic apply_reset(input bit noisy);
        rst_i        = 1'b1;
        start_i      = noisy;
        cfg_word_v_i = noisy;
        cfg_word_i   = $urandom;
        abort_i      = 1'b0;
        for (int pc = 0; pc < NUM_PC; pc++) begin
            mdl_conf[pc] = '0;
            mdl_eb[pc]   = '0;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk_i);
            chk_idle_zero("reset");
        end
        rst_i        = 1'b0;
        start_i      = 1'b0;
        cfg_word_v_i = 1'b0;
        tick();
    endtask

    // Drive one load from a start pulse, checking handshake outputs each cycle,
    // then fold the accepted words into the model.
    task automatic run_load(input vec_t v);
        int          wi = 0;
        int          gapcnt = 0;
        int          abort_cyc = -1;
        int          cyc = 1;
        int          last_busy;
        int          n_acc = 0;
        bit          aborted = 0;
        bit          finished = 0;
        bit          offered;
        bit          exp_busy;
        bit          exp_rdy;
        logic [31:0] acc [NWORDS];

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (!finished) begin
            offered      = (wi < NWORDS) && (gapcnt == 0) && !aborted;
            cfg_word_v_i = offered;
            cfg_word_i   = offered ? words[wi] : $urandom;
            abort_i      = 1'b0;
            if (offered && cyc >= 2 && wi == v.abort_at) begin
                abort_i   = 1'b1;
                aborted   = 1'b1;
                abort_cyc = cyc;
            end
            if (v.abort_done && cyc == v.exp_done) abort_i = 1'b1;
            start_i = v.poke_start && (cyc == 4 || cyc == v.exp_done);

            @(negedge clk_i);
            last_busy = aborted ? abort_cyc : ((v.exp_done > 0) ? v.exp_done - 1 : 1000);
            exp_busy  = (cyc <= last_busy);
            exp_rdy   = exp_busy && (cyc >= 2);
            chk1("clr_o",        clr_o,        cyc == 1);
            chk1("busy_o",       busy_o,       exp_busy);
            chk1("cfg_word_r_o", cfg_word_r_o, exp_rdy);
            chk1("done_o",       done_o,       cyc == v.exp_done);
            chk1("exec_en_o",    exec_en_o,    (v.exp_done > 0) && (cyc > v.exp_done));

            if (exp_rdy && offered) begin
                acc[n_acc] = words[wi];
                n_acc++;
                wi++;
                gapcnt = v.gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end

            if (v.exp_done > 0 && cyc >= v.exp_done + 1) finished = 1'b1;
            if (aborted && cyc >= abort_cyc + 3) finished = 1'b1;
            if (cyc >= 200) begin
                chkw("load_timeout", 128'(cyc), 128'(0));
                finished = 1'b1;
            end
            tick();
            cyc++;
        end
        cfg_word_v_i = 1'b0;
        abort_i      = 1'b0;
        start_i      = 1'b0;

        for (int pc = 0; pc < NUM_PC; pc++) begin
            if (n_acc >= 4 * (pc + 1)) begin
                mdl_conf[pc] = {acc[4*pc+3][11:0], acc[4*pc+2], acc[4*pc+1], acc[4*pc]};
                mdl_eb[pc]   = acc[4*pc+3][13:12];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        cfg_word_v_i = 1'b0;
        cfg_word_i   = '0;

        //             pre rnd gap abort poke abd done exec
        tbl[0] = '{1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 10, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 3, -1, 1'b0, 1'b0, 31, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 0,  6, 1'b0, 1'b0, -1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 10, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 0, -1, 1'b1, 1'b1, 10, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 0,  7, 1'b0, 1'b0, -1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1, -1, 1'b0, 1'b0, 17, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 0,  2, 1'b0, 1'b0, -1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 0, -1, 1'b0, 1'b0, 10, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 2, -1, 1'b0, 1'b0, 24, 1'b1};

        apply_reset(1'b1);

        for (int r = 0; r < NROWS; r++) begin
            if (tbl[r].pre_reset) apply_reset(1'b0);
            if (tbl[r].rnd) begin
                for (int i = 0; i < NWORDS; i++) words[i] = $urandom;
            end else begin
                fill_plan_words();
            end
            run_load(tbl[r]);
            @(negedge clk_i);
            chk_model();
            chk1($sformatf("exec_final_row%0d", r), exec_en_o, tbl[r].exp_exec);
            if (r == 0) begin
                chkw("plan_pc0_conf", 128'(conf_bits_o[0 +: CW]),
                     128'(108'hABC_33333333_22222222_11111111));
                chkw("plan_pc1_conf", 128'(conf_bits_o[CW +: CW]),
                     128'(108'hDEF_CCCCCCCC_BBBBBBBB_AAAAAAAA));
                chkw("plan_eb_en", 128'(eb_en_o), 128'(4'b0110));
            end
            tick();
        end

        // Randomized loads: random gaps, random abort points, random start pokes.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NWORDS; i++) words[i] = $urandom;
            rv.pre_reset  = 1'b0;
            rv.rnd        = 1'b1;
            rv.gap        = int'($urandom_range(0, 2));
            rv.abort_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NWORDS - 1)) : -1;
            if (rv.abort_at >= 0) rv.gap = 0;
            rv.poke_start = 1'($urandom_range(0, 1));
            rv.abort_done = 1'($urandom_range(0, 1));
            rv.exp_done   = (rv.abort_at >= 0) ? -1 : 2 + NWORDS + (NWORDS - 1) * rv.gap;
            rv.exp_exec   = (rv.abort_at < 0);
            run_load(rv);
            @(negedge clk_i);
            chk_model();
            chk1($sformatf("exec_final_rand%0d", it), exec_en_o, rv.exp_exec);
            tick();
        end

        // Reset in the middle of a load wipes committed slices and all outputs.
        fill_plan_words();
        start_i = 1'b1;
        tick();
        start_i      = 1'b0;
        cfg_word_v_i = 1'b1;
        cfg_word_i   = words[0];
        tick();
        for (int i = 0; i < 6; i++) begin
            cfg_word_i = words[i];
            tick();
        end
        cfg_word_v_i = 1'b0;
        @(negedge clk_i);
        chkw("midload_pc0_committed", 128'(conf_bits_o[0 +: CW]),
             128'(108'hABC_33333333_22222222_11111111));
        chk1("midload_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        for (int pc = 0; pc < NUM_PC; pc++) begin
            mdl_conf[pc] = '0;
            mdl_eb[pc]   = '0;
        end
        tick();
        @(negedge clk_i);
        chk_idle_zero("midload_rst");
        rst_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
